dmem_dump: RTL

Debug readout engine for the 8-bit data memory: on a start pulse it reads every data-memory location in ascending address order and streams each word out over a valid/ready handshake. It is the read-side counterpart of the core's execute-stage data-memory writes. It attaches to a data-memory read port while the core is halted and feeds a host or debug link. An optional trailing checksum word lets the receiver validate the dump.

---
 rtl/dmem_dump.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dmem_dump.sv
// dmem_dump: reads data memory 0..DEPTH-1 and streams each word out; DMEM_DUMP_CHECKSUM_EN appends a mod-2^DATA_W sum word.
// Latency: first o_valid 3 cycles after start is accepted, then 3 cycles per word with i_ready held high.
// Backpressure: SEND/CSUM hold every output while i_ready=0; each stalled cycle adds exactly one cycle.
module dmem_dump #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    output logic              o_is_csum
);

`ifdef DMEM_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, DONE} state_t;
`endif

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]   data_q, data_nxt;
    logic                last_word;

`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_nxt;
`endif

    assign last_word = (cnt == ADDR_W'(DEPTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            data_q <= data_nxt;
        end
    end

`ifdef DMEM_DUMP_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        data_nxt   = data_q;
`ifdef DMEM_DUMP_CHECKSUM_EN
        sum_nxt    = sum_q;
`endif
        o_busy     = (state != IDLE);
        o_done     = 1'b0;
        o_mem_en   = 1'b0;
        o_mem_addr = '0;
        o_valid    = 1'b0;
        o_data     = '0;
        o_addr     = '0;
        o_last     = 1'b0;
        o_is_csum  = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    cnt_nxt   = '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    sum_nxt   = '0;
`endif
                    state_nxt = READ;
                end
            end
            READ: begin
                o_mem_en   = 1'b1;
                o_mem_addr = cnt;
                state_nxt  = CAPT;
            end
            CAPT: begin
                // Read data is only valid in the cycle after the enable.
                data_nxt  = i_mem_rdata;
`ifdef DMEM_DUMP_CHECKSUM_EN
                sum_nxt   = sum_q + i_mem_rdata;
`endif
                state_nxt = SEND;
            end
            SEND: begin
                o_valid = 1'b1;
                o_data  = data_q;
                o_addr  = cnt;
`ifdef DMEM_DUMP_CHECKSUM_EN
                o_last  = 1'b0;
`else
                o_last  = last_word;
`endif
                if (i_ready) begin
                    if (last_word) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        state_nxt = CSUM;
`else
                        state_nxt = DONE;
`endif
                    end else begin
                        cnt_nxt   = cnt + ADDR_W'(1);
                        state_nxt = READ;
                    end
                end
            end
`ifdef DMEM_DUMP_CHECKSUM_EN
            CSUM: begin
                o_valid   = 1'b1;
                o_data    = sum_q;
                o_addr    = '0;
                o_last    = 1'b1;
                o_is_csum = 1'b1;
                if (i_ready) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
